// File: rtl/ysyx_24100005_lsu_if.sv
// Core/memory-facing bundle of the NPC load/store unit.
// master = core + memory side, slave = the LSU.
interface ysyx_24100005_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wmask;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output req_valid, req_wen, req_funct3,
    output req_addr, req_wdata, resp_ready,
    output mem_req_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, mem_req_valid, mem_wen,
    input  mem_addr, mem_wdata, mem_wmask
  );

  modport slave (
    input  req_valid, req_wen, req_funct3,
    input  req_addr, req_wdata, resp_ready,
    input  mem_req_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, mem_req_valid, mem_wen,
    output mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit (IDLE/REQ/WAIT/RESP).
// Define YSYX_24100005_LSU_MISALIGN_TRAP_EN to fault misaligned accesses.
module ysyx_24100005_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  ysyx_24100005_lsu_if.slave bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_t;

  state_t            state;
  logic              wen_q;
  logic [2:0]        f3_q;
  logic [OW-1:0]     off_q;
  logic              err_q;
  logic [XLEN-1:0]   rdata_q;
  logic              mwen_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [XLEN-1:0]   mwdata_q;
  logic [NB-1:0]     mmask_q;

  logic [2:0]        f3;
  logic [OW-1:0]     off;
  logic [7:0]        ones;
  logic [NB-1:0]     mask_w;
  logic [XLEN-1:0]   wsh;
  logic [XLEN-1:0]   rsh;
  logic [XLEN-1:0]   ext;
  logic              illegal;
  logic              misal;

  assign f3  = bus.req_funct3;
  assign off = bus.req_addr[OW-1:0];

  always_comb begin
    ones = 8'h01;
    unique case (f3[1:0])
      2'd0: ones = 8'h01;
      2'd1: ones = 8'h03;
      2'd2: ones = 8'h0F;
      2'd3: ones = 8'hFF;
    endcase
  end

  // Lanes past the aligned word fall off the top.
  assign mask_w = NB'(16'(ones) << off);
  assign wsh    = bus.req_wdata << {off, 3'b000};

  always_comb begin
    illegal = (f3 == 3'b111) || (bus.req_wen && f3[2]);
    if (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110))
      illegal = 1'b1;
  end

`ifdef YSYX_24100005_LSU_MISALIGN_TRAP_EN
  logic [2:0] amask;
  assign amask = 3'(4'(4'd1 << f3[1:0]) - 4'd1);
  assign misal = |(bus.req_addr[2:0] & amask);
`else
  assign misal = 1'b0;
`endif

  // Bytes shifted in from above the word read as zero.
  assign rsh = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = '0;
    unique case (1'b1)
      f3_q[1:0] == 2'd0:
        ext = f3_q[2] ? XLEN'(rsh[7:0])
                      : XLEN'($signed(rsh[7:0]));
      f3_q[1:0] == 2'd1:
        ext = f3_q[2] ? XLEN'(rsh[15:0])
                      : XLEN'($signed(rsh[15:0]));
      f3_q[1:0] == 2'd2:
        ext = f3_q[2] ? XLEN'(rsh[31:0])
                      : XLEN'($signed(rsh[31:0]));
      f3_q[1:0] == 2'd3:
        ext = rsh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wen_q    <= 1'b0;
      f3_q     <= 3'b000;
      off_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      mwen_q   <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mmask_q  <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.req_valid) begin
          wen_q   <= bus.req_wen;
          f3_q    <= f3;
          off_q   <= off;
          rdata_q <= '0;
          if (illegal || misal) begin
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            err_q    <= 1'b0;
            mwen_q   <= bus.req_wen;
            maddr_q  <= {bus.req_addr[ADDR_W-1:OW],
                         {OW{1'b0}}};
            mwdata_q <= bus.req_wen ? wsh : '0;
            mmask_q  <= bus.req_wen ? mask_w : '0;
            state    <= REQ;
          end
        end
        REQ: if (bus.mem_req_ready) state <= WAIT;
        WAIT: if (bus.mem_rvalid) begin
          if (!wen_q) rdata_q <= ext;
          state <= RESP;
        end
        RESP: if (bus.resp_ready) state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = (state == IDLE);
  assign bus.mem_req_valid = (state == REQ);
  assign bus.resp_valid    = (state == RESP);
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_err      = err_q;
  assign bus.mem_wen       = mwen_q;
  assign bus.mem_addr      = maddr_q;
  assign bus.mem_wdata     = mwdata_q;
  assign bus.mem_wmask     = mmask_q;
endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Randomized bench for ysyx_24100005_lsu against a byte-level model.
// Covers latency, backpressure, reset mid-WAIT and illegal sizes.
module tb_ysyx_24100005_lsu;
  localparam int XLEN = 32;
  localparam int AW   = 32;
`ifdef YSYX_24100005_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_24100005_lsu_if #(.XLEN(XLEN), .ADDR_W(AW)) bus ();

  ysyx_24100005_lsu #(.XLEN(XLEN), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input bit [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_bad(input bit wen,
                                input bit [2:0] f3,
                                input bit [31:0] a);
    bit ill;
    ill = (f3 == 7) || (f3 == 3) || (f3 == 6) ||
          (wen && f3 > 3);
    return ill || (TRAP && (a % size_of(f3)) != 0);
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f3,
                                       input int off,
                                       input bit [31:0] rd);
    int sz;
    bit [63:0] v;
    sz = size_of(f3);
    v = 0;
    for (int i = 0; i < sz; i++)
      if (off + i < 4)
        v |= ((64'(rd) >> (8 * (off + i))) & 64'hFF) << (8 * i);
    if (!f3[2] && sz < 4 && v[8*sz-1])
      v |= ~((64'd1 << (8 * sz)) - 1);
    return v[31:0];
  endfunction

  function automatic bit [3:0] m_mask(input bit [2:0] f3,
                                      input int off);
    bit [3:0] m;
    m = 0;
    for (int i = 0; i < size_of(f3); i++)
      if (off + i < 4) m[off+i] = 1'b1;
    return m;
  endfunction

  task automatic idle_inputs();
    bus.req_valid     = 1'b0;
    bus.req_wen       = 1'b0;
    bus.req_funct3    = 3'b000;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.resp_ready    = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  task automatic chk_reset_vals();
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_err", bus.resp_err, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_mem_req_valid", bus.mem_req_valid, 0);
    check("rst_mem_wen", bus.mem_wen, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_wmask", bus.mem_wmask, 0);
  endtask

  // One full transaction; bench acts as core and memory.
  task automatic txn(input bit wen, input bit [2:0] f3,
                     input bit [31:0] a, input bit [31:0] wd,
                     input bit [31:0] rd, input int req_lat,
                     input int resp_lat, input int bp,
                     output bit [31:0] got);
    int n, off;
    bit bad;
    bit [31:0] er;
    off = a % 4;
    bad = is_bad(wen, f3, a);
    er  = (bad || wen) ? 32'h0 : m_load(f3, off, rd);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_wen    = wen;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    if (bad) begin
      check("err_mem_req_valid", bus.mem_req_valid, 0);
    end else begin
      for (int i = 0; i <= req_lat; i++) begin
        check("mem_req_valid", bus.mem_req_valid, 1);
        check("req_resp_valid", bus.resp_valid, 0);
        check("mem_addr", bus.mem_addr, a & ~32'h3);
        check("mem_wen", bus.mem_wen, wen);
        check("mem_wmask", bus.mem_wmask,
              wen ? m_mask(f3, off) : 4'h0);
        if (wen)
          check("mem_wdata", bus.mem_wdata,
                32'(64'(wd) << (8 * off)));
        bus.mem_req_ready = (i == req_lat);
        bus.mem_rvalid = (i < req_lat) && 1'($urandom);
        bus.mem_rdata  = $urandom;
        @(posedge clk); #1;
      end
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i <= resp_lat; i++) begin
        check("wait_mem_req_valid", bus.mem_req_valid, 0);
        check("wait_resp_valid", bus.resp_valid, 0);
        bus.mem_rvalid = (i == resp_lat);
        bus.mem_rdata  = (i == resp_lat) ? rd : $urandom;
        @(posedge clk); #1;
      end
      bus.mem_rvalid = 1'b0;
    end
    check("resp_valid", bus.resp_valid, 1);
    check("resp_err", bus.resp_err, bad);
    check("resp_rdata", bus.resp_rdata, er);
    got = bus.resp_rdata;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check("bp_resp_valid", bus.resp_valid, 1);
      check("bp_resp_rdata", bus.resp_rdata, er);
      check("bp_req_ready", bus.req_ready, 0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("post_resp_valid", bus.resp_valid, 0);
  endtask

  initial begin
    bit [31:0] got;
    idle_inputs();
    rst = 1'b1;
    #1;
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    txn(1'b0, 3'b000, 32'h8000_0003, 32'h0,
        32'h80FF_1234, 0, 0, 0, got);
    check("lb_value", got, 32'hFFFF_FF80);

    txn(1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD,
        32'h0, 0, 0, 0, got);
    check("sh_rdata", got, 32'h0);

    txn(1'b0, 3'b010, 32'h8000_0008, 32'h0,
        32'h1357_9BDF, 4, 2, 3, got);

    txn(1'b0, 3'b010, 32'h8000_0002, 32'h0,
        32'hDDCC_BBAA, 0, 0, 0, got);
    check("lw_mis_value", got, TRAP ? 32'h0 : 32'h0000_DDCC);

    txn(1'b0, 3'b111, 32'h8000_0000, 32'h0,
        32'h0, 0, 0, 1, got);

    // Reset while waiting on memory read data.
    bus.req_valid  = 1'b1;
    bus.req_wen    = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h8000_0004;
    @(posedge clk); #1;
    bus.req_valid     = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    check("pre_rst_wait", bus.mem_req_valid, 0);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_rvalid_resp", bus.resp_valid, 0);
      check("late_rvalid_ready", bus.req_ready, 1);
      @(posedge clk); #1;
    end
    txn(1'b0, 3'b101, 32'h8000_0002, 32'h0,
        32'h8001_0000, 0, 0, 0, got);
    check("lhu_value", got, 32'h0000_8001);

    for (int k = 0; k < 80; k++) begin
      txn(1'($urandom), 3'($urandom),
          32'h8000_0000 | $urandom_range(0, 255),
          $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 2), got);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/ysyx_24100005_lsu.md
# ysyx_24100005_lsu

Parametrised multi-cycle load/store unit for the NPC core. It sits between the execute stage and the DPI-backed data memory, replacing direct combinational `npcmem_read` calls. It performs a valid/ready transaction with memory, drives byte-lane write masks, and returns extracted, sign- or zero-extended load data. Each request and each response is handshaken independently, so memory latency and core stalls are both tolerated.

## Interface
Parameters:
- `XLEN`, default 32: data width, 32 or 64; 64 enables `ld`/`sd`/`lwu`.
- `ADDR_W`, default 32: address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  core presents an access.
- `req_ready`  out  1  LSU accepts an access; high only in IDLE.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 (size/sign).
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  XLEN  store data, right-aligned.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  core consumes the result.
- `resp_rdata`  out  XLEN  extended load data; 0 for stores.
- `resp_err`  out  1  access fault: illegal size, or misaligned when the trap feature is enabled.
- `mem_req_valid`  out  1  memory request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_wen`  out  1  write request.
- `mem_addr`  out  ADDR_W  address aligned to XLEN/8.
- `mem_wdata`  out  XLEN  lane-shifted store data.
- `mem_wmask`  out  XLEN/8  byte enables; all zero for loads.
- `mem_rvalid`  in  1  read data or write acknowledge.
- `mem_rdata`  in  XLEN  full aligned word.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `wen`, `funct3`, `addr`, `wdata`.
  - Go to RESP with the error flag set if the access is illegal (or misaligned, when trapping). Otherwise go to REQ.
- REQ: `mem_req_valid`=1 with stable address, data and mask. Go to WAIT on `mem_req_ready`.
- WAIT:
  - On `mem_rvalid`, capture `mem_rdata`, then extract and extend it into `resp_rdata`. Stores ignore the data value.
  - Go to RESP.
  - `mem_rvalid` arriving in REQ is ignored.
- RESP: `resp_valid`=1, outputs held stable. Go to IDLE on `resp_ready`.
- Size decode, using lane offset `off = addr[log2(XLEN/8)-1:0]`:
  - 000 = b (sext)
  - 001 = h (sext)
  - 010 = w (sext when XLEN=64)
  - 011 = d
  - 100 = bu
  - 101 = hu
  - 110 = wu
  - 111 is illegal.
  - Codes 011 and 110 are illegal when XLEN=32.
  - Stores use only 000/001/010/011; other codes are illegal.
- Store: `mem_wdata = req_wdata << (8*off)`. `mem_wmask` = (size-bytes ones) << off, truncated to XLEN/8 bits.
- Load: `resp_rdata = ext((mem_rdata >> 8*off)[8*size-1:0])`.
- Illegal access: no memory request is issued, `resp_err`=1, `resp_rdata`=0.
- Reset at any point, including mid-REQ or mid-WAIT: return to IDLE and abandon the transaction. A late `mem_rvalid` arriving in IDLE is ignored.

## Timing
- Reset values:
  - `req_ready`=1.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - `mem_req_valid`=0, `mem_wen`=0.
  - `mem_addr`=0, `mem_wdata`=0, `mem_wmask`=0.
- All outputs are registered or decoded from state. There is no combinational path from `mem_rvalid` or `resp_ready` to any output.
- Minimum latency, with memory ready and responding immediately:
  - Accept in cycle 0.
  - REQ in cycle 1.
  - WAIT in cycle 2, with `mem_rvalid` also in cycle 2.
  - `resp_valid` in cycle 3.
- Error path: `resp_valid` in cycle 1.
- Back-to-back throughput: the next request is accepted in the cycle after the `resp_valid && resp_ready` handshake.
- `mem_req_valid` stays high until accepted and never drops early.

## Configuration
- `YSYX_24100005_LSU_MISALIGN_TRAP_EN`
  - Defined: any access with `addr` not a multiple of its size takes the error path and issues no memory request.
  - Undefined: misaligned accesses are performed within the aligned word. Mask bits beyond the word are dropped, and load bytes beyond the word read as 0. `resp_err` is driven only for illegal sizes.

## Test plan
- Load byte, sign-extended (`lb`), at 0x8000_0003 with `mem_rdata`=0x80FF_1234:
  - `mem_addr`=0x8000_0000, `mem_wmask`=0.
  - `resp_rdata`=0xFFFF_FF80, `resp_valid` 3 cycles after accept.
- Store halfword (`sh`) at 0x8000_0002 with `req_wdata`=0x0000_ABCD:
  - `mem_wdata`=0xABCD_0000, `mem_wmask`=4'b1100, `mem_wen`=1.
  - `resp_rdata`=0, `resp_err`=0.
- Backpressure:
  - Hold `mem_req_ready`=0 for 4 cycles: `mem_req_valid`/`mem_addr` stay stable.
  - Hold `resp_ready`=0 for 3 cycles: `resp_valid`/`resp_rdata` stay stable, and `req_ready`=0 throughout.
- Assert `rst` in WAIT, then pulse `mem_rvalid` after release:
  - All outputs at reset values.
  - No `resp_valid` is generated.
  - The next `lhu` at 0x8000_0002 with `mem_rdata`=0x8001_0000 returns 0x0000_8001.
- Load word (`lw`) at 0x8000_0002:
  - With the macro: `resp_err`=1 in cycle 1 and no `mem_req_valid`.
  - Without the macro: request to 0x8000_0000, and `mem_rdata`=0xDDCC_BBAA returns 0x0000_DDCC.
- Illegal funct3=111 load: `resp_err`=1 and no memory request, in both configurations.
